// File: rtl/err_correct.sv
// ---------------------------------------------------------------------------
// err_correct : single-error data-bit correction stage with a valid/ready
//               pipeline register and saturating error statistics counters.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module err_correct #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            NOF,
  input  logic [4:0]            NOE_Out,
  input  logic                  Small,
  input  logic                  Medium,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            err_status,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt
);

  localparam logic [1:0] NOF_NONE   = 2'b00;
  localparam logic [1:0] NOF_SINGLE = 2'b01;
  localparam logic [1:0] NOF_DOUBLE = 2'b10;

  logic [5:0]            width;
  logic [DATA_WIDTH-1:0] corrected;
  logic                  accept;
  logic                  is_single;
  logic                  is_multi;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_single = (NOF == NOF_SINGLE);
  assign is_multi  = (NOF != NOF_NONE) && !is_single;

  always_comb begin
    width = 6'd32;
    if (Small)
      width = 6'd8;
    else if (Medium)
      width = 6'd16;
  end

  // A syndrome pointing at or beyond the active width names a parity bit,
  // so only in-range positions are flipped; bits above the width are zeroed.
  always_comb begin
    corrected = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < 32 && 6'(i) < width)
        corrected[i] = data_in[i] ^ (is_single && (NOE_Out == 5'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      err_status <= NOF_NONE;
    end else if (accept) begin
      out_valid  <= 1'b1;
      data_out   <= corrected;
      err_status <= is_multi ? NOF_DOUBLE : NOF;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (accept) begin
      if (is_single && corr_cnt != '1)
        corr_cnt <= corr_cnt + 1'b1;
      if (is_multi && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_err_correct.sv
// ---------------------------------------------------------------------------
// tb_err_correct : randomized and directed bench for err_correct against a
//                  queue-based reference model.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_err_correct;

  localparam int CW = 8;
  localparam longint unsigned CMAX = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   data_in = '0;
  logic [1:0]    NOF = '0;
  logic [4:0]    NOE_Out = '0;
  logic          Small = 1'b0;
  logic          Medium = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   data_out;
  logic [1:0]    err_status;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  err_correct #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .NOF(NOF), .NOE_Out(NOE_Out), .Small(Small),
    .Medium(Medium), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_status(err_status), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  e;
  } word_t;

  word_t           exp_q[$];
  longint unsigned m_corr = 0;
  longint unsigned m_uncorr = 0;
  int              total = 0;
  int              bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_fix(input logic [31:0] d, input logic [1:0] nof,
                                            input logic [4:0] noe, input logic sm, input logic md);
    int w;
    longint unsigned r;
    w = sm ? 8 : (md ? 16 : 32);
    r = longint'(d) & ((64'd1 << w) - 1);
    if (nof == 2'b01 && int'(noe) < w)
      r = r ^ (64'd1 << noe);
    return r[31:0];
  endfunction

  // One clock cycle: drive at negedge, compare against the model, then
  // advance the model to what the coming rising edge must produce.
  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] nof,
                      input logic [4:0] noe, input logic sm, input logic md,
                      input logic ordy, input logic clr);
    logic  rdy;
    word_t w;
    @(negedge clk);
    in_valid = v; data_in = d; NOF = nof; NOE_Out = noe;
    Small = sm; Medium = md; out_ready = ordy; cnt_clr = clr;
    #1;
    rdy = (exp_q.size() == 0) || ordy;
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("data_out", data_out, exp_q[0].d);
      check("err_status", err_status, exp_q[0].e);
    end
    check("corr_cnt", corr_cnt, m_corr);
    check("uncorr_cnt", uncorr_cnt, m_uncorr);
    if (exp_q.size() != 0 && ordy)
      void'(exp_q.pop_front());
    if (v && rdy) begin
      w.d = model_fix(d, nof, noe, sm, md);
      w.e = (nof == 2'b11) ? 2'b10 : nof;
      exp_q.push_back(w);
    end
    if (clr) begin
      m_corr = 0;
      m_uncorr = 0;
    end else if (v && rdy) begin
      if (nof == 2'b01 && m_corr < CMAX) m_corr++;
      if (nof[1] && m_uncorr < CMAX) m_uncorr++;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // reset state while rst is held
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out", data_out, 32'h0);
    check("rst_err", err_status, 2'b00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_corr", corr_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // large mode, flip of bit 31
    step(1'b1, 32'h0000_0000, 2'b01, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("l_data", data_out, 32'h8000_0000);
    check("l_err", err_status, 2'b01);
    check("l_corr", corr_cnt, 1);

    // small mode, syndrome in the parity field
    step(1'b1, 32'hFFFF_FFA5, 2'b01, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("s_data", data_out, 32'h0000_00A5);
    check("s_corr", corr_cnt, 2);

    // medium mode, uncorrectable
    step(1'b1, 32'h0000_1234, 2'b10, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    check("m_data", data_out, 32'h0000_1234);
    check("m_err", err_status, 2'b10);
    check("m_uncorr", uncorr_cnt, 1);
    check("m_corr", corr_cnt, 2);

    // reserved code reported as double, both modes set selects small
    step(1'b1, 32'hABCD_EF5A, 2'b11, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();

    // three back-to-back words with a stall on the second output cycle
    step(1'b1, 32'h1111_1111, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h2222_2222, 2'b01, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h3333_3333, 2'b01, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3333_3333, 2'b01, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    idle();

    // saturation of corr_cnt, then clear beating a simultaneous increment
    step(1'b0, 32'h0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < (1 << CW); i++)
      step(1'b1, 32'($urandom), 2'b01, 5'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h5, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("sat_corr", corr_cnt, CMAX);
    step(1'b1, 32'h5, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check("clr_corr", corr_cnt, 0);
    idle();

    // asynchronous reset while a word is held on the output
    step(1'b1, 32'hDEAD_BEEF, 2'b01, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_data", data_out, 32'h0);
    check("arst_corr", corr_cnt, 0);
    check("arst_uncorr", uncorr_cnt, 0);
    check("arst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    m_corr = 0;
    m_uncorr = 0;
    #1;
    rst = 1'b0;
    step(1'b1, 32'h0000_00F0, 2'b01, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    check("post_rst_data", data_out, 32'h0000_00F1);
    check("post_rst_valid", out_valid, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 32'($urandom), 2'($urandom), 5'($urandom),
           ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 4) != 0,
           ($urandom % 40) == 0);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/err_correct.md
ERR_CORRECT -- requirements
Module: err_correct

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, the maximum data word width in bits.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, the width of each error statistics counter.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  the upstream word, NOF and NOE_Out are valid this cycle.
REQ-006 Port in_ready  output  1  the block accepts the input this cycle.
REQ-007 Port data_in  input  DATA_WIDTH  received data word, uncorrected.
REQ-008 Port NOF  input  2  number of errors from the syndrome stage: 00 none, 01 single, 10 double, 11 reserved.
REQ-009 Port NOE_Out  input  5  syndrome value giving the errored bit position.
REQ-010 Port Small  input  1  8-bit word mode.
REQ-011 Port Medium  input  1  16-bit word mode; Small=0 and Medium=0 select 32-bit mode; Small has priority if both are 1.
REQ-012 Port out_valid  output  1  data_out and err_status are valid.
REQ-013 Port out_ready  input  1  downstream accepts the output this cycle.
REQ-014 Port data_out  output  DATA_WIDTH  corrected data word.
REQ-015 Port err_status  output  2  registered copy of the NOF value for the word on data_out, with 11 reported as 10.
REQ-016 Port cnt_clr  input  1  synchronous clear of both counters.
REQ-017 Port corr_cnt  output  CNT_WIDTH  count of words with a single corrected error.
REQ-018 Port uncorr_cnt  output  CNT_WIDTH  count of words with double or reserved errors.

Function
REQ-019 The active width W SHALL be 8 in Small mode, 16 in Medium mode and 32 otherwise, sampled together with data_in.
REQ-020 The handshake SHALL complete on the input when in_valid and in_ready are both 1, and on the output when out_valid and out_ready are both 1.
REQ-021 in_ready SHALL equal (NOT out_valid) OR out_ready, so that back-to-back words pass at one word per cycle.
REQ-022 A word accepted in cycle N SHALL be presented on data_out with out_valid=1 in cycle N+1; latency is exactly 1 cycle.
REQ-023 When out_valid=1 and out_ready=0, data_out, err_status and out_valid SHALL hold unchanged.
REQ-024 out_valid SHALL fall after an output transfer when no new word is accepted in the same cycle.
REQ-025 For NOF=00, data_out SHALL equal data_in with bits at index W and above forced to 0.
REQ-026 For NOF=01 and NOE_Out < W, data_out SHALL equal data_in with bit NOE_Out inverted and bits at index W and above forced to 0.
REQ-027 For NOF=01 and NOE_Out >= W, the error lies in a parity bit and data_out SHALL equal the masked data_in, unchanged.
REQ-028 For NOF=10 or 11, data_out SHALL equal the masked data_in, uncorrected.
REQ-029 corr_cnt SHALL increment by 1 on each accepted word with NOF=01.
REQ-030 uncorr_cnt SHALL increment by 1 on each accepted word with NOF=10 or 11.
REQ-031 Both counters SHALL saturate at all-ones and not wrap.
REQ-032 cnt_clr=1 SHALL zero both counters and SHALL take priority over an increment in the same cycle.
REQ-033 Counting SHALL occur only on input handshake cycles; a stalled input SHALL not count.

Reset
REQ-034 Asserting rst SHALL immediately set out_valid=0, data_out=0, err_status=00, corr_cnt=0 and uncorr_cnt=0, independent of clk.
REQ-035 in_ready SHALL be 1 during and after reset.
REQ-036 Asserting rst while a word is held on the output SHALL discard that word.
REQ-037 The first word SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-038 Large mode, data_in=0x0000_0000, NOF=01, NOE_Out=31 -> data_out=0x8000_0000 and err_status=01 one cycle later; corr_cnt=1.
REQ-039 Small mode, data_in=0xFFFF_FFA5, NOF=01, NOE_Out=12 -> data_out=0x0000_00A5 (parity-bit error, no data flip); corr_cnt increments.
REQ-040 Medium mode, data_in=0x1234, NOF=10 -> data_out=0x0000_1234, err_status=10, uncorr_cnt=1, corr_cnt unchanged.
REQ-041 Three back-to-back words with out_ready=0 on the second output cycle -> second word held for two cycles, in_ready=0 during the stall, third word delivered intact, no word lost or duplicated.
REQ-042 Preload corr_cnt to all-ones via 2^CNT_WIDTH single-error words, then send one more -> value stays all-ones; assert cnt_clr together with a single-error word -> corr_cnt=0.
REQ-043 rst asserted mid-cycle while out_valid=1 -> out_valid=0 and counters=0 before the next clk edge; the next word after deassertion is output normally.
